// File: rtl/amplitude_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : amplitude_seq_ctrl_if
//  Description : Bundle between the magnitude sequencer and its environment
//                (MFCC state controller, FFT memory, datapath, amplitude
//                memory).
//                master : environment side (drives requests and datapath data)
//                slave  : sequencer side (drives strobes, addresses, status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface amplitude_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] fft_num;
    logic [DATA_WIDTH-1:0] ampli_data_in;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  dp_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] peak_val;
    logic [ADDR_WIDTH-1:0] peak_bin;

    modport master (
        output start, abort, fft_num, ampli_data_in,
        input  rd_en, rd_addr, dp_en, wr_en, wr_addr, busy, done,
               peak_val, peak_bin
    );

    modport slave (
        input  start, abort, fft_num, ampli_data_in,
        output rd_en, rd_addr, dp_en, wr_en, wr_addr, busy, done,
               peak_val, peak_bin
    );
endinterface
`default_nettype wire

// File: rtl/amplitude_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : amplitude_seq_ctrl
//  Description : Sequencer for the pipelined magnitude datapath. On start it
//                reads bins 0..(fft_num>>1)-1 one per cycle from the FFT
//                memory, enables the datapath, writes each result LATENCY
//                cycles after its read and pulses done when the last write
//                has retired.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - amplitude_seq_ctrl_if.slave
//                       in : start, abort, fft_num, ampli_data_in
//                       out: rd_en, rd_addr, dp_en, wr_en, wr_addr, busy,
//                            done, peak_val, peak_bin
//  Options     : AMP_PEAK_TRACK_EN - when defined, tracks the largest
//                amplitude of a pass and its bin index; otherwise
//                peak_val/peak_bin are tied to 0.
//  Parameters  : ADDR_WIDTH, DATA_WIDTH, LATENCY (legal range 1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
module amplitude_seq_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    amplitude_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_n_bins;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [LATENCY-1:0]    r_pipe;

    logic [ADDR_WIDTH-1:0] w_n_bins_in;
    logic                  w_start_ok;
    logic                  w_flush;
    logic                  w_rd_last;
    logic                  w_wr_last;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_pipe_tail_empty;

    assign w_n_bins_in = bus.fft_num >> 1;
    // abort beats start in IDLE; in any other state it cancels the pass
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_flush     = bus.abort && (r_state != S_IDLE);
    assign w_rd_last   = (r_rd_addr == r_n_bins - c_one);
    assign w_wr_last   = (r_wr_addr == r_n_bins - c_one);
    assign w_wr_en     = r_pipe[LATENCY-1];

    // ------------------------------------------------------------------
    // Valid pipe: tracks which issued reads are still in the datapath.
    // w_pipe_tail_empty means nothing is queued behind the top stage, so
    // a write seen in DRAIN under that condition is the last one.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (rst || w_flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= w_rd_en;
                end
            end
            assign w_pipe_tail_empty = 1'b1;
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst || w_flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[LATENCY-2:0], w_rd_en};
                end
            end
            assign w_pipe_tail_empty = ~|r_pipe[LATENCY-2:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok) begin
                    // an empty pass skips straight to the completion pulse
                    w_state_nxt = (w_n_bins_in == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rd_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pipe_tail_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pass length and address counters. Both counters saturate at the
    // last bin so they never point past the live half of the buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_bins  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else if (w_start_ok) begin
            r_n_bins  <= w_n_bins_in;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else if (w_flush) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else begin
            if (w_rd_en && !w_rd_last) begin
                r_rd_addr <= r_rd_addr + c_one;
            end
            if (w_wr_en && !w_wr_last) begin
                r_wr_addr <= r_wr_addr + c_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Peak tracking. Raw unsigned compare orders non-negative IEEE-754
    // singles correctly; strict '>' keeps the first of equal peaks.
    // ------------------------------------------------------------------
`ifdef AMP_PEAK_TRACK_EN
    logic [DATA_WIDTH-1:0] r_peak_val;
    logic [ADDR_WIDTH-1:0] r_peak_bin;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_peak_val <= '0;
            r_peak_bin <= '0;
        end else if (w_wr_en && (bus.ampli_data_in > r_peak_val)) begin
            r_peak_val <= bus.ampli_data_in;
            r_peak_bin <= r_wr_addr;
        end
    end

    assign bus.peak_val = r_peak_val;
    assign bus.peak_bin = r_peak_bin;
`else
    assign bus.peak_val = '0;
    assign bus.peak_bin = '0;
`endif

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.dp_en   = w_rd_en | (|r_pipe);
    assign bus.wr_en   = w_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

endmodule
`default_nettype wire
